// File: rtl/fib_ram_reader_if.sv
// rtl/fib_ram_reader_if.sv - address-tagged word stream between the RAM reader and its consumer
interface fib_ram_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [ADDR_W-1:0] m_index;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        output m_ready
    );
endinterface

// File: rtl/fib_ram_reader.sv
// rtl/fib_ram_reader.sv - sweeps RAM port B after generation and streams each word with its address
module fib_ram_reader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 31,
    parameter int RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                gen_done_i,
    output logic [ADDR_W-1:0]   addrb_o,
    input  logic [DATA_W-1:0]   doutb_i,
    fib_ram_reader_if.master    m_if,
    output logic                busy_o,
    output logic                done_o
);
    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [1:0]        LAT     = 2'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   addrb_q, addrb_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [ADDR_W-1:0]   m_index_q, m_index_d;
    logic                m_valid_q, m_valid_d;
    logic [1:0]          cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            addrb_q   <= '0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            addrb_q   <= addrb_d;
            m_data_q  <= m_data_d;
            m_index_q <= m_index_d;
            m_valid_q <= m_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        addrb_d   = addrb_q;
        m_data_d  = m_data_q;
        m_index_d = m_index_q;
        m_valid_d = m_valid_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && gen_done_i) begin
                    addr_d  = FIRST_A;
                    addrb_d = FIRST_A;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // doutb is valid in the cycle the counter reaches 1
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    m_data_d  = doutb_i;
                    m_index_d = addr_q;
                    m_valid_d = 1'b1;
                    state_d   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (m_valid_q && m_if.m_ready) begin
                    m_valid_d = 1'b0;
                    if (addr_q == LAST_A) begin
                        state_d = S_FINISH;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        addrb_d = addr_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign addrb_o      = addrb_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_data  = m_data_q;
    assign m_if.m_index = m_index_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_FINISH);
endmodule

// File: doc/fib_ram_reader.md
Name: fib_ram_reader

Overview:
Downstream consumer of the Fibonacci generation controller. Once generation has finished, it sweeps the data RAM's read port B from FIRST_ADDR to LAST_ADDR. Each word is presented as a valid/ready stream beat tagged with its address, for a display or serial output stage. It owns RAM port B only after generation is done; the generator releases addrb at that point.

Parameters:
ADDR_W, 6, RAM address width
DATA_W, 32, RAM word width
FIRST_ADDR, 0, first address read
LAST_ADDR, 31, last address read; FIRST_ADDR <= LAST_ADDR, otherwise a configuration error (not supported)
RD_LAT, 1, cycles from the RAM sampling addrb to doutb being valid (1 to 3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to begin a sweep
gen_done  in  1  generator finished (its write counter reached 31); level
addrb  out  ADDR_W  RAM port B read address (registered)
doutb  in  DATA_W  RAM port B read data
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts beat
m_data  out  DATA_W  word read from RAM
m_index  out  ADDR_W  address of m_data
busy  out  1  sweep in progress (state not IDLE)
done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset (rst high at a rising edge): state=IDLE; addr, addrb, m_index=0; m_data=0; m_valid, busy, done=0; wait counter=0. Reset overrides all other inputs. Reset mid-sweep aborts the sweep with no done pulse.
- States: IDLE, ISSUE, WAIT, PRESENT, FINISH.
- IDLE:
  - start=1 and gen_done=1: addr<=FIRST_ADDR, addrb<=FIRST_ADDR, go to ISSUE.
  - start with gen_done=0 is ignored.
- ISSUE: one cycle; the RAM samples addrb. Load the wait counter with RD_LAT, go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle the counter equals 1:
  - m_data<=doutb, m_index<=addr, m_valid<=1.
  - Go to PRESENT.
- PRESENT:
  - m_data and m_index are held stable while m_valid=1 and m_ready=0.
  - On m_valid and m_ready both high, m_valid<=0. Then:
    - addr==LAST_ADDR: go to FINISH.
    - Otherwise addr<=addr+1, addrb<=addr+1, go to ISSUE.
- FINISH: done=1 for exactly this one cycle, then IDLE.
- Latency, counting the edge that samples start as edge 1:
  - m_valid is visible after edge RD_LAT+2.
  - Each subsequent beat appears RD_LAT+2 cycles after the previous handshake.
- Address arithmetic is ADDR_W-bit unsigned. No wrap past LAST_ADDR: the sweep always terminates at LAST_ADDR.
- FIRST_ADDR==LAST_ADDR: exactly one beat, then done.
- start while busy=1 is ignored, including in the FINISH cycle.
- gen_done falling mid-sweep is ignored; the sweep completes.
- m_ready high while m_valid=0 has no effect.
- addrb holds its last value in IDLE; it never changes while state is WAIT or PRESENT.
- busy=1 in every state except IDLE, including FINISH.

Test Plan:
- Reset mid-sweep: rst high for one edge during WAIT -> all outputs 0 and state IDLE on the next cycle. No done pulse. A following start with gen_done=1 begins again from FIRST_ADDR.
- start with gen_done=0 -> busy stays 0, addrb stays 0, m_valid never asserts.
- Full sweep, m_ready tied high, RAM preloaded with the Fibonacci contents (RAM[0]=1, RAM[1]=1, RAM[n]=RAM[n-1]+RAM[n-2]):
  - Exactly 32 beats, m_index 0..31 in order.
  - m_data = 1, 1, 2, 3, 5 ... 2178309 at index 31.
  - Each beat appears 3 cycles after the previous handshake (RD_LAT=1).
  - done pulses once, 1 cycle after the index-31 handshake; busy falls the cycle after that.
- Backpressure: m_ready low for 5 cycles on beat index 7 -> m_valid stays 1, m_data=21 and m_index=7 stay constant, addrb stays 7. Index 8 (m_data=34) follows after release.
- A second start pulse at index 10 while busy=1 -> ignored; the beat sequence is uninterrupted.
- Parameter variant RD_LAT=3, FIRST_ADDR=LAST_ADDR=5 -> one beat, m_data=8, m_index=5, m_valid after edge 5, then done once.
